// File: rtl/athena_pkg.sv
// Shared Athena side-RAM types and the hiscore restore constants, state
// encoding and address-range helper.
package athena;

  typedef struct packed {
    logic [10:0] addr;
    logic [7:0]  data_in;
    logic        nCS;
    logic        nWE;
  } side_ram_t;

  localparam logic [10:0] HS_BASE = 11'h650;
  localparam int          HS_LEN  = 114;

  typedef logic [6:0] hs_idx_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_INJECT,
    ST_DONE
  } hs_restore_state_t;

  // True when a side-RAM address falls inside the hiscore table; no wrap at 11'h7ff.
  function automatic logic hs_in_range(input logic [10:0] addr);
    return (addr >= HS_BASE) && (addr <= HS_BASE + 11'(HS_LEN - 1));
  endfunction

endpackage

// File: rtl/athena_hiscore_buf.sv
// 128x8 shadow buffer. Port A serves the bridge (write + registered read),
// port B serves the injector (read) and the game-write mirror (write).
module athena_hiscore_buf (
  input  logic       game_clk,
  input  logic       reset_n,
  input  logic       a_we,
  input  logic [6:0] a_addr,
  input  logic [7:0] a_wdata,
  output logic [7:0] a_rdata,
  input  logic       b_we,
  input  logic [6:0] b_waddr,
  input  logic [7:0] b_wdata,
  input  logic [6:0] b_raddr,
  output logic [7:0] b_rdata
);

  logic [7:0] mem [128];
  logic       b_commit;

  // A mirror write to the same entry as a bridge write in the same cycle is dropped.
  assign b_commit = b_we && !(a_we && (a_addr == b_waddr));

  // NOTE: the storage array has no reset; contents after reset are whatever the
  // bridge last loaded, which keeps this mappable onto a block RAM.
  always_ff @(posedge game_clk) begin
    if (b_commit) mem[b_waddr] <= b_wdata;
    if (a_we)     mem[a_addr]  <= a_wdata;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge game_clk or negedge reset_n) begin
    if (!reset_n) begin
      a_rdata <= '0;
      b_rdata <= '0;
    end else begin
      a_rdata <= mem[a_addr];
      // Forward same-cycle writes so the injector never replays a stale byte.
      if (a_we && (a_addr == b_raddr))
        b_rdata <= a_wdata;
      else if (b_commit && (b_waddr == b_raddr))
        b_rdata <= b_wdata;
      else
        b_rdata <= mem[b_raddr];
    end
  end

endmodule

// File: rtl/athena_hiscore_restore.sv
// Restores saved hiscore bytes into side RAM using idle game bus slots, then
// mirrors game writes to the hiscore range back into the shadow buffer.
module athena_hiscore_restore
  import athena::*;
#(
  parameter int SETTLE_CYCLES = 1024
) (
  input  logic       game_clk,
  input  logic       reset_n,
  input  logic       hs_wr,
  input  logic [6:0] hs_addr,
  input  logic [7:0] hs_wdata,
  output logic [7:0] hs_rdata,
  input  logic       hs_loaded,
  input  logic       base_written,
  input  side_ram_t  side_ram_monitor,
  output side_ram_t  side_ram_in,
  output logic       restore_busy,
  output logic       restore_done
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam hs_idx_t          IDX_LAST    = hs_idx_t'(HS_LEN - 1);

  hs_restore_state_t state;
  hs_idx_t           idx;
  hs_idx_t           idx_next;
  hs_idx_t           mirror_idx;
  logic [CNT_W-1:0]  settle_cnt;
  logic              slot;
  logic              mirror_we;
  logic [7:0]        inj_data;

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    slot        = (state == ST_INJECT) && side_ram_monitor.nCS;
    idx_next    = slot ? idx + 7'd1 : idx;
    mirror_idx  = 7'(side_ram_monitor.addr - HS_BASE);
    mirror_we   = ((state == ST_INJECT) || (state == ST_DONE)) &&
                  !side_ram_monitor.nCS && !side_ram_monitor.nWE &&
                  hs_in_range(side_ram_monitor.addr);
    side_ram_in = side_ram_monitor;
    if (slot) begin
      side_ram_in.addr    = HS_BASE + 11'(idx);
      side_ram_in.data_in = inj_data;
      side_ram_in.nCS     = 1'b0;
      side_ram_in.nWE     = 1'b0;
    end
  end

  // The injector port reads idx_next so the byte for the next slot is always ready.
  athena_hiscore_buf u_buf (
    .game_clk (game_clk),
    .reset_n  (reset_n),
    .a_we     (hs_wr),
    .a_addr   (hs_addr),
    .a_wdata  (hs_wdata),
    .a_rdata  (hs_rdata),
    .b_we     (mirror_we),
    .b_waddr  (mirror_idx),
    .b_wdata  (side_ram_monitor.data_in),
    .b_raddr  (idx_next),
    .b_rdata  (inj_data)
  );

  always_ff @(posedge game_clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      idx          <= '0;
      settle_cnt   <= '0;
      restore_busy <= 1'b0;
      restore_done <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (hs_loaded && base_written) begin
            state        <= ST_SETTLE;
            settle_cnt   <= '0;
            restore_busy <= 1'b1;
          end
        end
        ST_SETTLE: begin
          if (settle_cnt == SETTLE_LAST) begin
            state <= ST_INJECT;
            idx   <= '0;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        ST_INJECT: begin
          if (slot) begin
            if (idx == IDX_LAST) begin
              state        <= ST_DONE;
              restore_busy <= 1'b0;
              restore_done <= 1'b1;
            end else begin
              idx <= idx_next;
            end
          end
        end
        ST_DONE: ;
      endcase
    end
  end

endmodule

// File: tb/tb_athena_hiscore_restore.sv
// Directed self-checking bench for athena_hiscore_restore.
module tb_athena_hiscore_restore;
  import athena::*;

  localparam int SETTLE = 1024;
  localparam int NBYTES = 114;
  localparam side_ram_t IDLE_REQ = '{addr: 11'h000, data_in: 8'h00, nCS: 1'b1, nWE: 1'b1};

  logic       game_clk = 1'b0;
  logic       reset_n;
  logic       hs_wr;
  logic [6:0] hs_addr;
  logic [7:0] hs_wdata;
  logic [7:0] hs_rdata;
  logic       hs_loaded;
  logic       base_written;
  side_ram_t  side_ram_monitor;
  side_ram_t  side_ram_in;
  logic       restore_busy;
  logic       restore_done;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 game_clk = ~game_clk;

  athena_hiscore_restore #(.SETTLE_CYCLES(SETTLE)) dut (
    .game_clk         (game_clk),
    .reset_n          (reset_n),
    .hs_wr            (hs_wr),
    .hs_addr          (hs_addr),
    .hs_wdata         (hs_wdata),
    .hs_rdata         (hs_rdata),
    .hs_loaded        (hs_loaded),
    .base_written     (base_written),
    .side_ram_monitor (side_ram_monitor),
    .side_ram_in      (side_ram_in),
    .restore_busy     (restore_busy),
    .restore_done     (restore_done)
  );

  function automatic side_ram_t exp_inj(input int k);
    return '{addr: 11'h650 + 11'(k), data_in: 8'hA0 ^ 8'(k), nCS: 1'b0, nWE: 1'b0};
  endfunction

  task automatic cyc();
    @(posedge game_clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n          = 1'b0;
    hs_wr            = 1'b0;
    hs_addr          = '0;
    hs_wdata         = '0;
    hs_loaded        = 1'b0;
    base_written     = 1'b0;
    side_ram_monitor = IDLE_REQ;
    repeat (3) cyc();
    reset_n = 1'b1;
    cyc();
  endtask

  task automatic load_buffer();
    for (int i = 0; i < NBYTES; i++) begin
      hs_wr    = 1'b1;
      hs_addr  = 7'(i);
      hs_wdata = 8'hA0 ^ 8'(i);
      cyc();
    end
    hs_wr   = 1'b0;
    hs_addr = '0;
  endtask

  task automatic test_reset();
    reset_n          = 1'b0;
    hs_wr            = 1'b0;
    hs_addr          = '0;
    hs_wdata         = '0;
    hs_loaded        = 1'b0;
    base_written     = 1'b0;
    side_ram_monitor = '{addr: 11'h123, data_in: 8'h45, nCS: 1'b0, nWE: 1'b1};
    #2;
    tests_run++;
    if (restore_busy !== 1'b0) begin
      tests_failed++; $display("FAIL reset_busy got=%b exp=0", restore_busy);
    end
    tests_run++;
    if (restore_done !== 1'b0) begin
      tests_failed++; $display("FAIL reset_done got=%b exp=0", restore_done);
    end
    tests_run++;
    if (hs_rdata !== 8'h00) begin
      tests_failed++; $display("FAIL reset_rdata got=%h exp=00", hs_rdata);
    end
    tests_run++;
    if (side_ram_in !== side_ram_monitor) begin
      tests_failed++; $display("FAIL reset_passthru got=%h exp=%h", side_ram_in, side_ram_monitor);
    end
    do_reset();
  endtask

  task automatic test_no_load();
    int errs = 0;
    do_reset();
    base_written = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      cyc();
      side_ram_monitor = '{addr: 11'(i * 7), data_in: 8'(i), nCS: (i % 3) != 0, nWE: i[1]};
      #1;
      if (side_ram_in !== side_ram_monitor) errs++;
      if (restore_busy !== 1'b0) errs++;
    end
    tests_run++;
    if (errs != 0) begin
      tests_failed++; $display("FAIL no_load_passthru got=%0d errors exp=0", errs);
    end
    tests_run++;
    if (restore_done !== 1'b0) begin
      tests_failed++; $display("FAIL no_load_done got=%b exp=0", restore_done);
    end
  endtask

  // Full restore; with gaps=1 the game occupies the bus on every odd cycle.
  task automatic test_restore(input bit gaps);
    int n = 0;
    int k = 0;
    int pt_errs = 0;
    side_ram_t last_inj = IDLE_REQ;
    do_reset();
    load_buffer();
    hs_loaded = 1'b1;
    cyc();
    base_written = 1'b1;
    tests_run++;
    if (restore_busy !== 1'b0) begin
      tests_failed++; $display("FAIL restore_busy_pre gaps=%0d got=%b exp=0", gaps, restore_busy);
    end
    while (k < NBYTES && n < 3000) begin
      @(posedge game_clk);
      #1;
      n++;
      if (gaps && n[0])
        side_ram_monitor = '{addr: 11'h100 + 11'(n[7:0]), data_in: 8'(n), nCS: 1'b0, nWE: n[1]};
      else
        side_ram_monitor = IDLE_REQ;
      #1;
      if (n == 1) begin
        tests_run++;
        if (restore_busy !== 1'b1) begin
          tests_failed++; $display("FAIL restore_busy_settle gaps=%0d got=%b exp=1", gaps, restore_busy);
        end
      end
      if (side_ram_monitor.nCS == 1'b0 || n < SETTLE + 1) begin
        if (side_ram_in !== side_ram_monitor) pt_errs++;
      end else begin
        tests_run++;
        if (side_ram_in !== exp_inj(k)) begin
          tests_failed++;
          $display("FAIL inject gaps=%0d k=%0d cycle=%0d got=%h exp=%h", gaps, k, n, side_ram_in, exp_inj(k));
        end
        last_inj = side_ram_in;
        k++;
      end
    end
    tests_run++;
    if (k != NBYTES) begin
      tests_failed++; $display("FAIL restore_timeout gaps=%0d got=%0d bytes exp=%0d", gaps, k, NBYTES);
    end
    tests_run++;
    if (pt_errs != 0) begin
      tests_failed++; $display("FAIL restore_passthru gaps=%0d got=%0d errors exp=0", gaps, pt_errs);
    end
    tests_run++;
    if (last_inj !== side_ram_t'({11'h6c1, 8'hD1, 1'b0, 1'b0})) begin
      tests_failed++; $display("FAIL restore_last gaps=%0d got=%h exp=6c1/d1", gaps, last_inj);
    end
    cyc();
    side_ram_monitor = IDLE_REQ;
    #1;
    tests_run++;
    if (restore_done !== 1'b1 || restore_busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL restore_done gaps=%0d got done=%b busy=%b exp done=1 busy=0", gaps, restore_done, restore_busy);
    end
    tests_run++;
    if (side_ram_in !== IDLE_REQ) begin
      tests_failed++; $display("FAIL after_done_passthru gaps=%0d got=%h exp=%h", gaps, side_ram_in, IDLE_REQ);
    end
  endtask

  // Runs in DONE state left by the previous restore.
  task automatic test_mirror();
    side_ram_monitor = '{addr: 11'h660, data_in: 8'h55, nCS: 1'b0, nWE: 1'b0};
    #1;
    tests_run++;
    if (side_ram_in !== side_ram_monitor) begin
      tests_failed++; $display("FAIL mirror_passthru got=%h exp=%h", side_ram_in, side_ram_monitor);
    end
    cyc();
    side_ram_monitor = '{addr: 11'h700, data_in: 8'h77, nCS: 1'b0, nWE: 1'b0};
    cyc();
    side_ram_monitor = IDLE_REQ;
    hs_addr = 7'd16;
    cyc();
    tests_run++;
    if (hs_rdata !== 8'h55) begin
      tests_failed++; $display("FAIL mirror_in_range got=%h exp=55", hs_rdata);
    end
    hs_addr = 7'd48;
    cyc();
    tests_run++;
    if (hs_rdata !== 8'h90) begin
      tests_failed++; $display("FAIL mirror_out_of_range got=%h exp=90", hs_rdata);
    end
    hs_addr = 7'd15;
    cyc();
    tests_run++;
    if (hs_rdata !== 8'hAF) begin
      tests_failed++; $display("FAIL mirror_neighbour15 got=%h exp=af", hs_rdata);
    end
    hs_addr = 7'd17;
    cyc();
    tests_run++;
    if (hs_rdata !== 8'hB1) begin
      tests_failed++; $display("FAIL mirror_neighbour17 got=%h exp=b1", hs_rdata);
    end
  endtask

  task automatic test_collision();
    hs_wr            = 1'b1;
    hs_addr          = 7'd5;
    hs_wdata         = 8'h3C;
    side_ram_monitor = '{addr: 11'h655, data_in: 8'hC3, nCS: 1'b0, nWE: 1'b0};
    cyc();
    hs_wr            = 1'b0;
    side_ram_monitor = IDLE_REQ;
    cyc();
    tests_run++;
    if (hs_rdata !== 8'h3C) begin
      tests_failed++; $display("FAIL collision_bridge_wins got=%h exp=3c", hs_rdata);
    end
    side_ram_monitor = '{addr: 11'h656, data_in: 8'h5A, nCS: 1'b0, nWE: 1'b0};
    cyc();
    side_ram_monitor = IDLE_REQ;
    hs_addr = 7'd6;
    cyc();
    tests_run++;
    if (hs_rdata !== 8'h5A) begin
      tests_failed++; $display("FAIL mirror_alone got=%h exp=5a", hs_rdata);
    end
  endtask

  task automatic test_reset_mid_inject();
    int n = 0;
    int k = 0;
    int errs = 0;
    do_reset();
    load_buffer();
    hs_loaded    = 1'b1;
    base_written = 1'b1;
    while (k < 40 && n < 3000) begin
      cyc();
      n++;
      if (side_ram_in.nCS == 1'b0) begin
        tests_run++;
        if (side_ram_in !== exp_inj(k)) begin
          tests_failed++; $display("FAIL abort_inject k=%0d got=%h exp=%h", k, side_ram_in, exp_inj(k));
        end
        k++;
      end
    end
    cyc();
    tests_run++;
    if (side_ram_in !== exp_inj(40) || restore_busy !== 1'b1 || hs_rdata !== 8'hA0) begin
      tests_failed++;
      $display("FAIL abort_pre got=%h busy=%b rdata=%h exp=%h busy=1 rdata=a0", side_ram_in, restore_busy, hs_rdata, exp_inj(40));
    end
    reset_n = 1'b0;
    #1;
    tests_run++;
    if (side_ram_in !== IDLE_REQ || restore_busy !== 1'b0 || restore_done !== 1'b0 || hs_rdata !== 8'h00) begin
      tests_failed++;
      $display("FAIL abort_async got=%h busy=%b done=%b rdata=%h exp=%h 0 0 00", side_ram_in, restore_busy, restore_done, hs_rdata, IDLE_REQ);
    end
    hs_loaded    = 1'b0;
    base_written = 1'b0;
    repeat (2) cyc();
    reset_n = 1'b1;
    for (int i = 0; i < 200; i++) begin
      cyc();
      side_ram_monitor = (i % 4 == 0) ? side_ram_t'({11'h660, 8'(i), 1'b0, 1'b0}) : IDLE_REQ;
      #1;
      if (side_ram_in !== side_ram_monitor) errs++;
      if (restore_busy !== 1'b0 || restore_done !== 1'b0) errs++;
    end
    tests_run++;
    if (errs != 0) begin
      tests_failed++; $display("FAIL abort_after got=%0d errors exp=0", errs);
    end
  endtask

  initial begin
    test_reset();
    test_no_load();
    test_restore(1'b0);
    test_restore(1'b1);
    test_mirror();
    test_collision();
    test_reset_mid_inject();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
